fifo_push_arb: RTL and testbench



---
 rtl/fifo_push_arb.sv | 173 +++++++++++++++++
 tb/tb_fifo_push_arb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arb.sv
// fifo_push_arb: round-robin arbiter that shares one FIFO write port
// among NREQ producers, with occupancy tracking and underflow flag.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req[NREQ]         per-producer request (payload valid)
//   lock[NREQ]        per-producer burst-lock request
//   req_data          producer i payload at [i*WIDTH +: WIDTH]
//   gnt[NREQ]         one-hot-or-zero same-cycle grant
//   fifo_full         FIFO full flag
//   fifo_pop          copy of the consumer's FIFO pop
//   fifo_push         FIFO push strobe (= |gnt)
//   fifo_data         {src_id, payload} to FIFO data_in, zero when idle
//   count             registered FIFO occupancy, 0..DEPTH
//   almost_full       registered, count >= DEPTH-AF_SLACK
//   underflow_err     sticky, pop seen while count == 0
//
// Build option: define FIFO_ARB_LOCK_EN to enable burst locking.
// Without it, lock is ignored and arbitration is pure round-robin.

module fifo_push_arb #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_SLACK = 2,
    parameter int IDW      = $clog2(NREQ),
    parameter int CNTW     = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        lock,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    output logic [NREQ-1:0]        gnt,
    input  logic                   fifo_full,
    input  logic                   fifo_pop,
    output logic                   fifo_push,
    output logic [WIDTH+IDW-1:0]   fifo_data,
    output logic [CNTW-1:0]        count,
    output logic                   almost_full,
    output logic                   underflow_err
);

    localparam logic [IDW-1:0]  LAST_RST = IDW'(NREQ - 1);
    localparam logic [CNTW-1:0] AF_LEVEL = CNTW'(DEPTH - AF_SLACK);

    logic [IDW-1:0]   last;
    logic [IDW-1:0]   rr_cand;
    logic             rr_found;
    logic [IDW-1:0]   sel;
    logic             sel_valid;
    logic             grant;
    logic [WIDTH-1:0] payload;
    logic             pop_eff;
    logic [CNTW-1:0]  count_next;

`ifdef FIFO_ARB_LOCK_EN
    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] owner;
`else
    // lock has no function in this build
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // Round-robin search. Each requester gets its distance from the
    // slot after last (modulo NREQ); the smallest distance wins, so
    // last+1 has top priority and last itself has the lowest.
    always_comb begin
        int d;
        int best_d;
        d        = 0;
        best_d   = NREQ;
        rr_found = 1'b0;
        rr_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - int'(last) - 1 + 2 * NREQ) % NREQ;
            if (req[i] && d < best_d) begin
                best_d   = d;
                rr_found = 1'b1;
                rr_cand  = IDW'(i);
            end
        end
    end

    // Pick the producer to serve: the lock owner while locked,
    // otherwise the round-robin candidate.
    always_comb begin
        sel       = rr_cand;
        sel_valid = rr_found;
`ifdef FIFO_ARB_LOCK_EN
        if (state == LOCKED) begin
            sel       = owner;
            sel_valid = req[owner];
        end
`endif
    end

    // No grant while the FIFO is full or during the reset cycle, so
    // the FIFO is never overwritten and a reset never pushes.
    assign grant     = sel_valid && !fifo_full && !rst;
    assign fifo_push = grant;

    always_comb begin
        payload = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == IDW'(i)) begin
                payload = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = grant && (sel == IDW'(i));
        end
    end

    assign fifo_data = grant ? {sel, payload} : '0;

    // Occupancy: a pop against an empty queue is not counted.
    assign pop_eff    = fifo_pop && (count != '0);
    assign count_next = count + CNTW'(grant) - CNTW'(pop_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            last          <= LAST_RST;
            count         <= '0;
            almost_full   <= 1'b0;
            underflow_err <= 1'b0;
`ifdef FIFO_ARB_LOCK_EN
            state         <= ARB;
            owner         <= '0;
`endif
        end else begin
            if (grant) begin
                last <= sel;
            end
            count       <= count_next;
            almost_full <= (count_next >= AF_LEVEL);
            if (fifo_pop && count == '0) begin
                underflow_err <= 1'b1;
            end
`ifdef FIFO_ARB_LOCK_EN
            unique case (state)
                ARB: begin
                    if (grant && lock[sel]) begin
                        state <= LOCKED;
                        owner <= sel;
                    end
                end
                LOCKED: begin
                    // Leave on the owner's last beat, or as soon as
                    // the owner stops requesting.
                    if (!req[owner]) begin
                        state <= ARB;
                    end else if (grant && !lock[owner]) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench for fifo_push_arb: directed scenarios plus a
// randomized run compared every cycle against a behavioural model.

module tb_fifo_push_arb;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8;
    localparam int AF_SLACK = 2;
    localparam int IDW      = 2;
    localparam int CNTW     = 4;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_full;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic [WIDTH+IDW-1:0]  fifo_data;
    logic [CNTW-1:0]       count;
    logic                  almost_full;
    logic                  underflow_err;

    fifo_push_arb #(
        .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_SLACK(AF_SLACK)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .req_data(req_data), .gnt(gnt), .fifo_full(fifo_full),
        .fifo_pop(fifo_pop), .fifo_push(fifo_push),
        .fifo_data(fifo_data), .count(count),
        .almost_full(almost_full), .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    // Behavioural model state
    int m_last;
    int m_count;
    bit m_uf;
    bit m_locked;
    int m_owner;
    logic [WIDTH+IDW-1:0] q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_sel();
        int i;
        if (rst || fifo_full) return -1;
`ifdef FIFO_ARB_LOCK_EN
        if (m_locked) return req[m_owner] ? m_owner : -1;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            i = (m_last + k) % NREQ;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    // Called just after inputs are driven at the falling edge.
    task automatic pre();
        fifo_full = (q.size() == DEPTH);
        #1;
    endtask

    // Compare against the model, then advance it across the next
    // rising edge, and return at the following falling edge.
    task automatic post();
        int e;
        logic [31:0] eg;
        logic [31:0] ed;
        logic [1:0]  id;
        e  = exp_sel();
        eg = 0;
        ed = 0;
        if (e >= 0) begin
            id = e[1:0];
            eg = 32'(1) << e;
            ed = 32'({id, req_data[e*WIDTH +: WIDTH]});
        end
        if (checking) begin
            chk("gnt", 32'(gnt), eg);
            chk("push", 32'(fifo_push), 32'(e >= 0));
            chk("data", 32'(fifo_data), ed);
            chk("count", 32'(count), 32'(m_count));
            chk("almost_full", 32'(almost_full),
                32'(m_count >= DEPTH - AF_SLACK));
            chk("underflow", 32'(underflow_err), 32'(m_uf));
        end
        if (rst) begin
            m_last   = NREQ - 1;
            m_count  = 0;
            m_uf     = 1'b0;
            m_locked = 1'b0;
            m_owner  = 0;
            q.delete();
        end else begin
            if (fifo_pop) begin
                if (m_count == 0) m_uf = 1'b1;
                else m_count--;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (e >= 0) begin
                m_count++;
                m_last = e;
                q.push_back(ed[WIDTH+IDW-1:0]);
            end
`ifdef FIFO_ARB_LOCK_EN
            if (!m_locked) begin
                if (e >= 0 && lock[e]) begin
                    m_locked = 1'b1;
                    m_owner  = e;
                end
            end else if (!req[m_owner] || (e >= 0 && !lock[m_owner])) begin
                m_locked = 1'b0;
            end
`endif
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; lock = '0; fifo_pop = 1'b0;
        pre(); post();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; fifo_pop = 1'b0;
        fifo_full = 1'b0;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        @(negedge clk);
        do_reset();
        checking = 1'b1;

        // Reset state, idle inputs
        pre();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_uf", 32'(underflow_err), 0);
        chk("rst_data", 32'(fifo_data), 0);
        post();

        // All four request, no pops: rotate 0..3 until full
        req = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            pre();
            if (c < 8) begin
                chk("rr_gnt", 32'(gnt), 32'(1) << (c % 4));
                chk("rr_data", 32'(fifo_data),
                    32'(((c % 4) << 8) | (8'hA0 + c % 4)));
            end else begin
                chk("full_gnt", 32'(gnt), 0);
            end
            chk("rr_count", 32'(count), 32'(c));
            chk("rr_af", 32'(almost_full), 32'(c >= 6));
            post();
        end

        // Full: pop one, producer 2 waits one cycle then is served
        req = 4'b0100; fifo_pop = 1'b1;
        pre();
        chk("popfull_gnt", 32'(gnt), 0);
        post();
        fifo_pop = 1'b0;
        pre();
        chk("refill_gnt", 32'(gnt), 32'b0100);
        chk("refill_count", 32'(count), 7);
        post();
        req = '0;
        pre();
        chk("refill_count2", 32'(count), 8);
        post();

        // Alternating priority between producers 1 and 3
        do_reset();
        req = 4'b0010;
        pre(); chk("alt_g1", 32'(gnt), 32'b0010); post();
        req = 4'b1010;
        pre(); chk("alt_g3", 32'(gnt), 32'b1000); post();
        pre(); chk("alt_g1b", 32'(gnt), 32'b0010); post();

        // Underflow is sticky until reset
        do_reset();
        fifo_pop = 1'b1;
        pre(); chk("uf_before", 32'(underflow_err), 0); post();
        fifo_pop = 1'b0;
        pre();
        chk("uf_set", 32'(underflow_err), 1);
        chk("uf_count", 32'(count), 0);
        post();
        pre(); post();
        pre(); chk("uf_sticky", 32'(underflow_err), 1); post();
        do_reset();
        pre(); chk("uf_cleared", 32'(underflow_err), 0); post();

`ifdef FIFO_ARB_LOCK_EN
        begin
            int exp_l[7] = '{2, 2, 2, 2, 3, 0, 1};
            do_reset();
            req = 4'b0010;
            pre(); post();
            req = 4'b1111;
            for (int j = 0; j < 7; j++) begin
                lock = (j < 3) ? 4'b0100 : 4'b0000;
                pre();
                chk("lock_gnt", 32'(gnt), 32'(1) << exp_l[j]);
                post();
            end
        end
        do_reset();
        req = 4'b1111; lock = 4'b0001;
        pre(); chk("ldrop_g0", 32'(gnt), 32'b0001); post();
        req = 4'b1110;
        pre(); chk("ldrop_none", 32'(gnt), 0); post();
        pre(); chk("ldrop_g1", 32'(gnt), 32'b0010); post();
        do_reset();
        req = 4'b0100; lock = 4'b0100;
        pre(); chk("lrst_g2", 32'(gnt), 32'b0100); post();
        rst = 1'b1; req = 4'b1111;
        pre(); chk("lrst_nopush", 32'(gnt), 0); post();
        rst = 1'b0; lock = '0;
        pre();
        chk("lrst_g0", 32'(gnt), 32'b0001);
        chk("lrst_count", 32'(count), 0);
        post();
`endif

        // Randomized run against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            req      = 4'($urandom);
            lock     = 4'($urandom & $urandom);
            fifo_pop = ($urandom_range(0, 9) < 4);
            req_data = 32'($urandom);
            pre();
            post();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
